// File: rtl/timer_compare.sv
// timer_compare: 64-bit compare register with sticky match interrupt.
// Compares the free-running counter value against {TCMP1,TCMP0} and latches
// a sticky status bit on the first cycle of equality. TIER masks the request.
// Optional build macro TIMER_CMP_PULSE_EN adds a one-cycle int_pulse output.
module timer_compare #(
  parameter logic [63:0] CMP_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter logic [2:0]  SEL_TCMP0   = 3'd3,
  parameter logic [2:0]  SEL_TCMP1   = 3'd4,
  parameter logic [2:0]  SEL_TIER    = 3'd5,
  parameter logic [2:0]  SEL_TISR    = 3'd6
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [63:0] cnt,
  input  logic [2:0]  wr_sel,
  input  logic [3:0]  pstrb,
  input  logic [31:0] wdt,
  output logic [63:0] cmp_val,
  output logic        int_en,
  output logic        int_st,
  output logic        tim_int
`ifdef TIMER_CMP_PULSE_EN
  ,
  output logic        int_pulse
`endif
);

  logic        match_now;
  logic        match_q;
  logic        match_rise;
  logic        st_clr;
  logic [63:0] cmp_nxt;

  assign match_now  = (cnt == cmp_val);
  assign match_rise = match_now & ~match_q;
  assign st_clr     = (wr_sel == SEL_TISR) & pstrb[0] & wdt[0];
  assign tim_int    = int_en & int_st;

  // Byte-lane merge of APB write data into the compare register.
  always_comb begin
    cmp_nxt = cmp_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if ((wr_sel == SEL_TCMP0) && pstrb[i])
        cmp_nxt[8*i +: 8] = wdt[8*i +: 8];
      if ((wr_sel == SEL_TCMP1) && pstrb[i])
        cmp_nxt[32 + 8*i +: 8] = wdt[8*i +: 8];
    end
  end

  // Compare, enable and status registers; a match edge beats a W1C clear.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cmp_val <= CMP_DEFAULT;
      int_en  <= 1'b0;
      int_st  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      cmp_val <= cmp_nxt;
      if ((wr_sel == SEL_TIER) && pstrb[0])
        int_en <= wdt[0];
      if (match_rise)
        int_st <= 1'b1;
      else if (st_clr)
        int_st <= 1'b0;
      match_q <= match_now;
    end
  end

`ifdef TIMER_CMP_PULSE_EN
  // Registered match edge: high in the same cycle int_st first becomes 1.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      int_pulse <= 1'b0;
    else
      int_pulse <= match_rise;
  end
`endif

endmodule

// File: tb/tb_timer_compare.sv
// tb_timer_compare: directed scenarios plus randomized traffic, checked by a
// scoreboard fed from a cycle-level behavioural model of the compare block.
module tb_timer_compare;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [63:0] cnt     = '0;
  logic [2:0]  wr_sel  = '0;
  logic [3:0]  pstrb   = '0;
  logic [31:0] wdt     = '0;
  logic [63:0] cmp_val;
  logic        int_en;
  logic        int_st;
  logic        tim_int;
  logic        int_pulse;

  timer_compare #(
    .CMP_DEFAULT (64'hFFFF_FFFF_FFFF_FFFF),
    .SEL_TCMP0   (3'd3),
    .SEL_TCMP1   (3'd4),
    .SEL_TIER    (3'd5),
    .SEL_TISR    (3'd6)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .cnt       (cnt),
    .wr_sel    (wr_sel),
    .pstrb     (pstrb),
    .wdt       (wdt),
    .cmp_val   (cmp_val),
    .int_en    (int_en),
    .int_st    (int_st),
    .tim_int   (tim_int)
`ifdef TIMER_CMP_PULSE_EN
    ,
    .int_pulse (int_pulse)
`endif
  );

`ifndef TIMER_CMP_PULSE_EN
  assign int_pulse = 1'b0;
`endif

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [63:0] cmp;
    logic        en;
    logic        st;
    logic        tim;
    logic        pulse;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state: register contents after the most recent edge.
  logic [63:0] m_cmp   = '0;
  logic        m_en    = 1'b0;
  logic        m_st    = 1'b0;
  logic        m_eq    = 1'b0;
  logic        m_pulse = 1'b0;

  // Advance the model by one clock edge using the values being driven now.
  task automatic model_step();
    logic eq;
    logic first;
    exp_t e;
    eq    = (cnt == m_cmp);
    first = eq && !m_eq;
    if (sys_rst) begin
      m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
      m_en    = 1'b0;
      m_st    = 1'b0;
      m_eq    = 1'b0;
      m_pulse = 1'b0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (wr_sel == 3'd3 && pstrb[b]) m_cmp[8*b +: 8]      = wdt[8*b +: 8];
        if (wr_sel == 3'd4 && pstrb[b]) m_cmp[32 + 8*b +: 8] = wdt[8*b +: 8];
      end
      if (wr_sel == 3'd5 && pstrb[0]) m_en = wdt[0];
      if (first) m_st = 1'b1;
      else if (wr_sel == 3'd6 && pstrb[0] && wdt[0]) m_st = 1'b0;
      m_eq    = eq;
      m_pulse = first;
    end
    e.cmp   = m_cmp;
    e.en    = m_en;
    e.st    = m_st;
    e.tim   = m_en && m_st;
`ifdef TIMER_CMP_PULSE_EN
    e.pulse = m_pulse;
`else
    e.pulse = 1'b0;
`endif
    q.push_back(e);
  endtask

  // One cycle of stimulus, driven on the falling edge.
  task automatic apply(input logic r, input logic [63:0] c, input logic [2:0] s,
                       input logic [3:0] st, input logic [31:0] d);
    @(negedge sys_clk);
    sys_rst = r;
    cnt     = c;
    wr_sel  = s;
    pstrb   = st;
    wdt     = d;
    model_step();
  endtask

  // Monitor: after each rising edge, pop the expected state and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (cmp_val !== e.cmp) begin
          miscompares++;
          $display("FAIL cmp_val t=%0t got=%h exp=%h", $time, cmp_val, e.cmp);
        end
        vectors++;
        if (int_en !== e.en) begin
          miscompares++;
          $display("FAIL int_en t=%0t got=%b exp=%b", $time, int_en, e.en);
        end
        vectors++;
        if (int_st !== e.st) begin
          miscompares++;
          $display("FAIL int_st t=%0t got=%b exp=%b", $time, int_st, e.st);
        end
        vectors++;
        if (tim_int !== e.tim) begin
          miscompares++;
          $display("FAIL tim_int t=%0t got=%b exp=%b", $time, tim_int, e.tim);
        end
`ifdef TIMER_CMP_PULSE_EN
        vectors++;
        if (int_pulse !== e.pulse) begin
          miscompares++;
          $display("FAIL int_pulse t=%0t got=%b exp=%b", $time, int_pulse, e.pulse);
        end
`endif
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] c;
    logic [2:0]  s;
    logic [31:0] d;
    int unsigned r;

    // Reset for two cycles.
    apply(1'b1, 64'd0, 3'd0, 4'h0, 32'h0);
    apply(1'b1, 64'd0, 3'd0, 4'h0, 32'h0);

    // Byte-lane writes.
    apply(1'b0, 64'd0, 3'd3, 4'b0101, 32'hAABB_CCDD);
    apply(1'b0, 64'd0, 3'd4, 4'hF, 32'h0);

    // Match with interrupt enabled.
    apply(1'b0, 64'd0, 3'd3, 4'hF, 32'h10);
    apply(1'b0, 64'd0, 3'd5, 4'h1, 32'h1);
    apply(1'b0, 64'h0E, 3'd0, 4'h0, 32'h0);
    apply(1'b0, 64'h0F, 3'd0, 4'h0, 32'h0);
    apply(1'b0, 64'h10, 3'd0, 4'h0, 32'h0);
    apply(1'b0, 64'h11, 3'd0, 4'h0, 32'h0);

    // W1C while equality is held, no re-trigger.
    apply(1'b0, 64'h10, 3'd0, 4'h0, 32'h0);
    apply(1'b0, 64'h10, 3'd6, 4'h1, 32'h1);
    for (int i = 0; i < 3; i++) apply(1'b0, 64'h10, 3'd0, 4'h0, 32'h0);
    // Re-arm, then a write of 0 must not clear.
    apply(1'b0, 64'h11, 3'd0, 4'h0, 32'h0);
    apply(1'b0, 64'h10, 3'd0, 4'h0, 32'h0);
    apply(1'b0, 64'h10, 3'd6, 4'h1, 32'h0);
    // Strobe low must not clear either.
    apply(1'b0, 64'h10, 3'd6, 4'h0, 32'h1);

    // Set/clear collision.
    apply(1'b0, 64'h11, 3'd6, 4'h1, 32'h1);
    apply(1'b0, 64'h10, 3'd6, 4'h1, 32'h1);
    apply(1'b0, 64'h10, 3'd0, 4'h0, 32'h0);

    // Masked match, enable, then reset with writes pending.
    apply(1'b0, 64'h11, 3'd5, 4'h1, 32'hFFFF_FFFE);
    apply(1'b0, 64'h11, 3'd6, 4'h1, 32'h1);
    apply(1'b0, 64'h10, 3'd0, 4'h0, 32'h0);
    apply(1'b0, 64'h10, 3'd0, 4'h0, 32'h0);
    apply(1'b0, 64'h10, 3'd5, 4'h1, 32'h1);
    apply(1'b0, 64'h10, 3'd0, 4'h0, 32'h0);
    apply(1'b1, 64'h10, 3'd3, 4'hF, 32'h1234_5678);
    apply(1'b0, 64'h10, 3'd0, 4'h0, 32'h0);

    // Wrap-around match at zero, with TCMP1 written first.
    apply(1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 3'd4, 4'hF, 32'h0);
    apply(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3, 4'hF, 32'h0);
    apply(1'b0, 64'h0, 3'd0, 4'h0, 32'h0);
    apply(1'b0, 64'h1, 3'd0, 4'h0, 32'h0);

    // Unused select codes leave state alone.
    for (int k = 0; k < 3; k++) apply(1'b0, 64'h5, 3'(k), 4'hF, 32'hFFFF_FFFF);
    apply(1'b0, 64'h5, 3'd7, 4'hF, 32'hFFFF_FFFF);

    // Randomized traffic with the compare value kept near the counter.
    c = {32'h0, $urandom};
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       c = c + 64'd1;
      else if (r == 6) c = c - 64'd2;
      else if (r == 7) c = {$urandom_range(0, 1) == 0 ? 32'h0 : $urandom, $urandom};
      s = 3'($urandom_range(0, 7));
      case (s)
        3'd3:    d = (c[31:0] + 32'($urandom_range(0, 6))) ^ ($urandom_range(0, 3) == 0 ? $urandom : 32'h0);
        3'd4:    d = ($urandom_range(0, 2) == 0) ? $urandom : c[63:32];
        3'd5,
        3'd6:    d = $urandom;
        default: d = $urandom;
      endcase
      apply($urandom_range(0, 199) == 0, c,
            s, ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF, d);
    end

    apply(1'b0, c, 3'd0, 4'h0, 32'h0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
